if_fetch_unit: RTL and testbench

//  Instruction-fetch stage that drives the IF/ID pipeline register: holds the PC and issues
//  one-outstanding requests to instruction memory. Presents {instr_out, pc_out, instr_valid}
//  to IF/ID, honours the IF/ID stall, and flushes or redirects on a taken branch from EX.

---
 rtl/if_fetch_unit.sv | 126 ++++++++++++
 tb/tb_if_fetch_unit.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage feeding IF/ID: one outstanding imem request, stall hold, branch redirect, halt.
// Optional trace output when IF_FETCH_TRACE_EN is defined (port behaviour unchanged).
module if_fetch_unit #(
  parameter int                PC_W      = 8,
  parameter int                INSN_W    = 32,
  parameter logic [PC_W-1:0]   RESET_PC  = '0,
  parameter int                PC_STEP   = 4,
  parameter logic [INSN_W-1:0] HALT_INSN = 32'h00000073
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_valid,
  input  logic [INSN_W-1:0] imem_rdata,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [PC_W-1:0]   branch_target,
  output logic              instr_valid,
  output logic [INSN_W-1:0] instr_out,
  output logic [PC_W-1:0]   pc_out,
  output logic              halted,
  output logic [15:0]       fetch_count
);

  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_DRAIN, S_HALTED} state_t;

  state_t              state_reg;
  logic [PC_W-1:0]     pc_reg;
  logic                instr_valid_reg;
  logic [INSN_W-1:0]   instr_out_reg;
  logic [PC_W-1:0]     pc_out_reg;
  logic                halted_reg;
  logic [15:0]         fetch_count_reg;

  logic                accept;
  logic                issue;
  logic                capture;
  logic [PC_W-1:0]     redirect_pc;

  assign accept      = instr_valid_reg && !stall;
  // Never issue while IF/ID is holding a live instruction, so a capture always finds the output free.
  assign issue       = (state_reg == S_FETCH) && !(instr_valid_reg && stall) && !branch_taken;
  assign capture     = (state_reg == S_WAIT) && imem_valid && !branch_taken;
  assign redirect_pc = branch_target & ~PC_W'(3);

  assign imem_req    = issue && !rst;
  assign imem_addr   = pc_reg;
  assign instr_valid = instr_valid_reg;
  assign instr_out   = instr_out_reg;
  assign pc_out      = pc_out_reg;
  assign halted      = halted_reg;
  assign fetch_count = fetch_count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= S_FETCH;
      pc_reg          <= RESET_PC;
      instr_valid_reg <= 1'b0;
      instr_out_reg   <= '0;
      pc_out_reg      <= '0;
      halted_reg      <= 1'b0;
      fetch_count_reg <= '0;
    end else if (branch_taken) begin
      // Flush: the live instruction is dropped without being counted.
      pc_reg          <= redirect_pc;
      instr_valid_reg <= 1'b0;
      halted_reg      <= 1'b0;
      case (state_reg)
        S_WAIT:  state_reg <= imem_valid ? S_FETCH : S_DRAIN;
        S_DRAIN: state_reg <= S_DRAIN;
        default: state_reg <= S_FETCH;
      endcase
    end else begin
      if (accept) begin
        fetch_count_reg <= fetch_count_reg + 16'd1;
        instr_valid_reg <= 1'b0;
      end
      case (state_reg)
        S_FETCH: begin
          if (issue) state_reg <= S_WAIT;
        end
        S_WAIT: begin
          if (capture) begin
            instr_out_reg   <= imem_rdata;
            pc_out_reg      <= pc_reg;
            instr_valid_reg <= 1'b1;
            pc_reg          <= pc_reg + PC_W'(PC_STEP);
            if (imem_rdata == HALT_INSN) begin
              state_reg  <= S_HALTED;
              halted_reg <= 1'b1;
            end else begin
              state_reg  <= S_FETCH;
            end
          end
        end
        S_DRAIN: begin
          if (imem_valid) state_reg <= S_FETCH;
        end
        default: ;
      endcase
    end
  end

`ifdef IF_FETCH_TRACE_EN
  function automatic string op_class(input logic [6:0] op);
    case (op)
      7'b0110011: return "R";
      7'b0010011: return "I";
      7'b0000011: return "LD";
      7'b0100011: return "SD";
      7'b1100011: return "BEQ";
      default:    return "undef";
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!rst && capture)
      $display("[if_fetch] t=%0t pc=%h insn=%h class=%s", $time, pc_reg, imem_rdata,
               op_class(imem_rdata[6:0]));
    if (!rst && branch_taken)
      $display("[if_fetch] t=%0t redirect pc %h -> %h", $time, pc_reg, redirect_pc);
  end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a small latency-configurable instruction memory responder.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_valid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [7:0]  branch_target = '0;
  logic        instr_valid;
  logic [31:0] instr_out;
  logic [7:0]  pc_out;
  logic        halted;
  logic [15:0] fetch_count;

  int tests  = 0;
  int failed = 0;

  logic [31:0] mem [0:63];
  int          mem_lat = 1;

  if_fetch_unit dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .instr_valid(instr_valid), .instr_out(instr_out), .pc_out(pc_out),
    .halted(halted), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("[TB] check %-14s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Memory responder: sees requests 2ns after the falling edge, answers mem_lat cycles later.
  initial begin
    logic       pend;
    int         pend_cnt;
    logic [7:0] pend_addr;
    pend = 1'b0;
    pend_cnt = 0;
    pend_addr = '0;
    forever begin
      @(negedge clk);
      #2;
      imem_valid = 1'b0;
      if (pend) begin
        if (pend_cnt <= 1) begin
          imem_valid = 1'b1;
          imem_rdata = mem[pend_addr[7:2]];
          pend = 1'b0;
        end else begin
          pend_cnt--;
        end
      end
      if (imem_req) begin
        pend = 1'b1;
        pend_cnt = mem_lat;
        pend_addr = imem_addr;
      end
    end
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h00000013 + (32'(i) << 12);
    mem[8] = 32'h00000073;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_pc_out", {24'b0, pc_out}, 32'h00);
    chk("rst_instr", instr_out, 32'h0);
    chk("rst_halted", {31'b0, halted}, 32'd0);
    chk("rst_count", {16'b0, fetch_count}, 32'd0);

    // 1: sequential fetch at 1-cycle latency
    @(negedge clk); rst = 1'b0; #1;                       // c0
    chk("t1_req0", {31'b0, imem_req}, 32'd1);
    chk("t1_addr0", {24'b0, imem_addr}, 32'h00);
    step();                                                // c1
    chk("t1_gap0", {31'b0, instr_valid}, 32'd0);
    chk("t1_noreq1", {31'b0, imem_req}, 32'd0);
    step();                                                // c2
    chk("t1_valid0", {31'b0, instr_valid}, 32'd1);
    chk("t1_pc0", {24'b0, pc_out}, 32'h00);
    chk("t1_insn0", instr_out, mem[0]);
    chk("t1_addr4", {24'b0, imem_addr}, 32'h04);
    step();                                                // c3
    chk("t1_gap1", {31'b0, instr_valid}, 32'd0);
    step();                                                // c4
    chk("t1_pc4", {24'b0, pc_out}, 32'h04);
    chk("t1_addr8", {24'b0, imem_addr}, 32'h08);
    step();                                                // c5
    step();                                                // c6
    chk("t1_pc8", {24'b0, pc_out}, 32'h08);
    chk("t1_insn8", instr_out, mem[2]);
    step();                                                // c7
    chk("t1_count3", {16'b0, fetch_count}, 32'd3);

    // 2: stall for 4 cycles while instruction at 0x0C is live
    @(negedge clk); stall = 1'b1; #1;                      // c8
    chk("t2_valid", {31'b0, instr_valid}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step();                                   // c9..c11
      chk("t2_hold_pc", {24'b0, pc_out}, 32'h0C);
      chk("t2_hold_insn", instr_out, mem[3]);
      chk("t2_noreq", {31'b0, imem_req}, 32'd0);
    end
    chk("t2_count", {16'b0, fetch_count}, 32'd3);
    @(negedge clk); stall = 1'b0; mem_lat = 2; #1;         // c12
    chk("t2_rel_req", {31'b0, imem_req}, 32'd1);
    chk("t2_rel_addr", {24'b0, imem_addr}, 32'h10);
    step();                                                // c13
    chk("t2_count4", {16'b0, fetch_count}, 32'd4);

    // 3: redirect to 0x43 while waiting on a 2-cycle response
    branch_taken = 1'b1; branch_target = 8'h43;
    #1;
    chk("t3_br_noreq", {31'b0, imem_req}, 32'd0);
    @(negedge clk); branch_taken = 1'b0; #1;               // c14: stale response arrives
    chk("t3_drain_valid", {31'b0, instr_valid}, 32'd0);
    chk("t3_drain_noreq", {31'b0, imem_req}, 32'd0);
    step();                                                // c15
    chk("t3_req", {31'b0, imem_req}, 32'd1);
    chk("t3_addr", {24'b0, imem_addr}, 32'h40);
    step();                                                // c16
    chk("t3_gap_a", {31'b0, instr_valid}, 32'd0);
    step();                                                // c17
    chk("t3_gap_b", {31'b0, instr_valid}, 32'd0);
    step();                                                // c18
    chk("t3_valid", {31'b0, instr_valid}, 32'd1);
    chk("t3_pc", {24'b0, pc_out}, 32'h40);
    chk("t3_insn", instr_out, mem[16]);

    // 4: flush the live instruction, redirect to 0xFC and check the wrap
    branch_taken = 1'b1; branch_target = 8'hFC; mem_lat = 1;
    #1;
    chk("t4_gated_req", {31'b0, imem_req}, 32'd0);
    @(negedge clk); branch_taken = 1'b0; #1;               // c19
    chk("t4_flush_valid", {31'b0, instr_valid}, 32'd0);
    chk("t4_flush_count", {16'b0, fetch_count}, 32'd4);
    chk("t4_addr_fc", {24'b0, imem_addr}, 32'hFC);
    step();                                                // c20
    step();                                                // c21
    chk("t4_pc_fc", {24'b0, pc_out}, 32'hFC);
    chk("t4_wrap_req", {31'b0, imem_req}, 32'd1);
    chk("t4_wrap_addr", {24'b0, imem_addr}, 32'h00);
    step();                                                // c22
    step();                                                // c23
    chk("t4_pc_00", {24'b0, pc_out}, 32'h00);
    chk("t4_count5", {16'b0, fetch_count}, 32'd5);

    // 5: halt at 0x20, then resume by redirect to 0x10
    branch_taken = 1'b1; branch_target = 8'h20;
    @(negedge clk); branch_taken = 1'b0; #1;               // c24
    chk("t5_addr", {24'b0, imem_addr}, 32'h20);
    step();                                                // c25
    step();                                                // c26
    chk("t5_halted", {31'b0, halted}, 32'd1);
    chk("t5_halt_valid", {31'b0, instr_valid}, 32'd1);
    chk("t5_halt_insn", instr_out, 32'h00000073);
    chk("t5_halt_noreq", {31'b0, imem_req}, 32'd0);
    for (int k = 0; k < 10; k++) begin
      step();                                              // c27..c36
      chk("t5_idle_noreq", {31'b0, imem_req}, 32'd0);
    end
    chk("t5_count6", {16'b0, fetch_count}, 32'd6);
    chk("t5_still_halt", {31'b0, halted}, 32'd1);
    @(negedge clk); branch_taken = 1'b1; branch_target = 8'h10; mem_lat = 2; #1;  // c37
    @(negedge clk); branch_taken = 1'b0; #1;               // c38
    chk("t5_resume_halt", {31'b0, halted}, 32'd0);
    chk("t5_resume_req", {31'b0, imem_req}, 32'd1);
    chk("t5_resume_addr", {24'b0, imem_addr}, 32'h10);

    // 6: reset while waiting; the late response must be ignored
    @(negedge clk); rst = 1'b1; #1;                        // c39
    @(negedge clk); rst = 1'b0; #1;                        // c40
    chk("t6_valid", {31'b0, instr_valid}, 32'd0);
    chk("t6_pc_out", {24'b0, pc_out}, 32'h00);
    chk("t6_instr", instr_out, 32'h0);
    chk("t6_count", {16'b0, fetch_count}, 32'd0);
    chk("t6_halted", {31'b0, halted}, 32'd0);
    chk("t6_req_addr", {24'b0, imem_addr}, 32'h00);
    chk("t6_req", {31'b0, imem_req}, 32'd1);
    step();                                                // c41
    chk("t6_ignored", {31'b0, instr_valid}, 32'd0);
    step();                                                // c42
    chk("t6_wait", {31'b0, instr_valid}, 32'd0);
    step();                                                // c43
    chk("t6_first_valid", {31'b0, instr_valid}, 32'd1);
    chk("t6_first_pc", {24'b0, pc_out}, 32'h00);
    chk("t6_first_insn", instr_out, mem[0]);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
